// File: rtl/ram_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram_io_responder
// Brief    : Byte RAM plus memory-mapped UART TX FIFO, RX holding register,
//            status byte and halt register behind the controller's RAM port.
// Revision : 1.0 - initial release
// ============================================================================
module ram_io_responder #(
  parameter int ADDR_W      = 17,
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_ena,
  input  logic        wr_mc2ram,
  input  logic [31:0] addr_2ram,
  input  logic [7:0]  data_2ram,
  output logic [7:0]  data_from_ram,
  output logic        uart_full_signal,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halt,
  output logic        tx_overflow
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_depth   = CW'(TX_DEPTH);
  localparam logic [CW-1:0] c_full_at = CW'(TX_DEPTH - FULL_MARGIN);

  logic [7:0]    r_mem  [0:(2**ADDR_W)-1];
  logic [7:0]    r_fifo [0:TX_DEPTH-1];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_rdata, r_rx_byte;
  logic          r_rx_full, r_halt, r_overflow;

  logic          w_io, w_rd, w_wr, w_off0, w_off4;
  logic          w_push_req, w_push, w_pop, w_rx_rd, w_rx_cap;
  logic [7:0]    w_rdata_next;
  logic          w_unused;

  assign w_io    = (addr_2ram[17:16] == 2'b11);
  assign w_rd    = ram_ena & ~wr_mc2ram;
  assign w_wr    = ram_ena & wr_mc2ram;
  assign w_off0  = (addr_2ram[15:0] == 16'h0000);
  assign w_off4  = (addr_2ram[15:0] == 16'h0004);
  assign w_unused = ^addr_2ram[31:18];

  assign tx_valid         = (r_count != '0);
  assign tx_data          = r_fifo[r_rd_ptr];
  assign uart_full_signal = (r_count >= c_full_at);
  assign rx_ready         = ~r_rx_full;
  assign halt             = r_halt;
  assign tx_overflow      = r_overflow;
  assign data_from_ram    = r_rdata;

  assign w_pop      = tx_valid & tx_ready;
  assign w_push_req = w_wr & w_io & w_off0;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_push     = w_push_req & ((r_count < c_depth) | w_pop);
  assign w_rx_rd    = w_rd & w_io & w_off0;
  assign w_rx_cap   = rx_valid & rx_ready;

  always_comb begin
    w_rdata_next = r_rdata;
    if (w_rd) begin
      if (!w_io)
        w_rdata_next = r_mem[addr_2ram[ADDR_W-1:0]];
      else if (w_off0)
        w_rdata_next = r_rx_full ? r_rx_byte : 8'h00;
      else if (w_off4)
        w_rdata_next = {6'b0, r_rx_full, (r_count == '0)};
      else
        w_rdata_next = 8'h00;
    end
  end

  // Storage arrays are deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_wr && !w_io)
      r_mem[addr_2ram[ADDR_W-1:0]] <= data_2ram;
    if (w_push)
      r_fifo[r_wr_ptr] <= data_2ram;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata    <= 8'h00;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rx_byte  <= 8'h00;
      r_rx_full  <= 1'b0;
      r_halt     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rdata <= w_rdata_next;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push_req && !w_push)
        r_overflow <= 1'b1;
      if (w_wr && w_io && w_off4)
        r_halt <= 1'b1;
      // A capture wins over the clear from a data-register read.
      if (w_rx_cap) begin
        r_rx_byte <= rx_data;
        r_rx_full <= 1'b1;
      end else if (w_rx_rd) begin
        r_rx_full <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_io_responder
// Brief    : Directed self-checking bench for ram_io_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_io_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_ena, wr_mc2ram, tx_ready, rx_valid;
  logic [31:0] addr_2ram;
  logic [7:0]  data_2ram, rx_data;
  logic [7:0]  data_from_ram, tx_data;
  logic        uart_full_signal, tx_valid, rx_ready, halt, tx_overflow;

  int checks = 0;
  int errors = 0;

  ram_io_responder #(.ADDR_W(17), .TX_DEPTH(8), .FULL_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .ram_ena(ram_ena), .wr_mc2ram(wr_mc2ram),
    .addr_2ram(addr_2ram), .data_2ram(data_2ram), .data_from_ram(data_from_ram),
    .uart_full_signal(uart_full_signal), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .halt(halt), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  // Advance one active edge; outputs are sampled 1 ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] d);
    ram_ena = 1'b1; wr_mc2ram = 1'b1; addr_2ram = a; data_2ram = d;
    cyc();
    ram_ena = 1'b0; wr_mc2ram = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    ram_ena = 1'b1; wr_mc2ram = 1'b0; addr_2ram = a;
    cyc();
    ram_ena = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    ram_ena = 0; wr_mc2ram = 0; addr_2ram = 0; data_2ram = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    rst = 1'b1;
    cyc(); cyc();
    checks++;
    if ({data_from_ram, tx_valid, rx_ready, halt, tx_overflow, uart_full_signal} !== {8'h00, 5'b01000}) begin
      errors++;
      $display("FAIL reset_state: got %h_%b%b%b%b%b want 00_01000", data_from_ram,
               tx_valid, rx_ready, halt, tx_overflow, uart_full_signal);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_ram_single();
    do_write(32'h100, 8'hA5);
    do_read(32'h100);
    checks++;
    if (data_from_ram !== 8'hA5) begin
      errors++; $display("FAIL ram_single_read: got %h want a5", data_from_ram);
    end
    cyc();
    checks++;
    if (data_from_ram !== 8'hA5) begin
      errors++; $display("FAIL ram_idle_hold: got %h want a5", data_from_ram);
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp [4];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
    for (int i = 0; i < 4; i++) do_write(32'h200 + i, exp[i]);
    ram_ena = 1'b1; wr_mc2ram = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_2ram = 32'h200 + i;
      cyc();
      checks++;
      if (data_from_ram !== exp[i]) begin
        errors++; $display("FAIL burst_byte%0d: got %h want %h", i, data_from_ram, exp[i]);
      end
    end
    ram_ena = 1'b0;
    do_write(32'h300, 8'hEE);
    checks++;
    if (data_from_ram !== 8'h44) begin
      errors++; $display("FAIL write_keeps_rdata: got %h want 44", data_from_ram);
    end
  endtask

  task automatic test_tx_fill();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do_write(32'h30000, 8'h10 + 8'(i));
      if (i == 4) begin
        checks++;
        if (uart_full_signal !== 1'b0) begin
          errors++; $display("FAIL full_at_5: got %b want 0", uart_full_signal);
        end
      end
    end
    checks++;
    if ({uart_full_signal, tx_valid, tx_data} !== {2'b11, 8'h10}) begin
      errors++; $display("FAIL full_at_6: got %b%b_%h want 11_10", uart_full_signal, tx_valid, tx_data);
    end
    do_write(32'h30000, 8'h16);
    do_write(32'h30000, 8'h17);
    checks++;
    if (tx_overflow !== 1'b0) begin
      errors++; $display("FAIL no_overflow_at_8: got %b want 0", tx_overflow);
    end
    do_write(32'h30000, 8'h18);
    checks++;
    if ({tx_overflow, tx_data} !== {1'b1, 8'h10}) begin
      errors++; $display("FAIL overflow_at_9: got %b_%h want 1_10", tx_overflow, tx_data);
    end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp [8];
    // Push into empty FIFO while ready is high: only a push happens.
    tx_ready = 1'b1;
    do_write(32'h30000, 8'h10);
    tx_ready = 1'b0;
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h10}) begin
      errors++; $display("FAIL push_empty_ready: got %b_%h want 1_10", tx_valid, tx_data);
    end
    for (int i = 1; i < 8; i++) do_write(32'h30000, 8'h10 + 8'(i));
    tx_ready = 1'b1;
    do_write(32'h30000, 8'h20);
    tx_ready = 1'b0;
    checks++;
    if ({tx_overflow, uart_full_signal, tx_data} !== {2'b01, 8'h11}) begin
      errors++; $display("FAIL full_push_pop: got %b%b_%h want 01_11", tx_overflow, uart_full_signal, tx_data);
    end
    for (int i = 0; i < 7; i++) exp[i] = 8'h11 + 8'(i);
    exp[7] = 8'h20;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({tx_valid, tx_data} !== {1'b1, exp[i]}) begin
        errors++; $display("FAIL drain_%0d: got %b_%h want 1_%h", i, tx_valid, tx_data, exp[i]);
      end
      cyc();
    end
    tx_ready = 1'b0;
    checks++;
    if ({tx_valid, uart_full_signal, tx_overflow} !== 3'b000) begin
      errors++; $display("FAIL drained_empty: got %b%b%b want 000", tx_valid, uart_full_signal, tx_overflow);
    end
  endtask

  task automatic test_rx();
    rx_data = 8'h5A; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0; rx_data = 8'h00;
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++; $display("FAIL rx_captured: got rx_ready %b want 0", rx_ready);
    end
    do_read(32'h30004);
    checks++;
    if (data_from_ram !== 8'h03) begin
      errors++; $display("FAIL status_full: got %h want 03", data_from_ram);
    end
    do_read(32'h30000);
    checks++;
    if ({data_from_ram, rx_ready} !== {8'h5A, 1'b1}) begin
      errors++; $display("FAIL rx_read: got %h_%b want 5a_1", data_from_ram, rx_ready);
    end
    do_read(32'h30000);
    checks++;
    if (data_from_ram !== 8'h00) begin
      errors++; $display("FAIL rx_read_empty: got %h want 00", data_from_ram);
    end
    do_read(32'h30004);
    checks++;
    if (data_from_ram !== 8'h01) begin
      errors++; $display("FAIL status_empty: got %h want 01", data_from_ram);
    end
    do_write(32'h30008, 8'h77);
    do_read(32'h30008);
    checks++;
    if ({data_from_ram, tx_valid, halt} !== {8'h00, 2'b00}) begin
      errors++; $display("FAIL io_other: got %h_%b%b want 00_00", data_from_ram, tx_valid, halt);
    end
  endtask

  task automatic test_halt_reset();
    do_write(32'h30004, 8'h00);
    checks++;
    if (halt !== 1'b1) begin
      errors++; $display("FAIL halt_set: got %b want 1", halt);
    end
    for (int i = 0; i < 3; i++) do_write(32'h30000, 8'h40 + 8'(i));
    tx_ready = 1'b1;
    cyc();
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h41}) begin
      errors++; $display("FAIL mid_drain: got %b_%h want 1_41", tx_valid, tx_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tx_valid, halt, data_from_ram} !== {2'b00, 8'h00}) begin
      errors++; $display("FAIL async_reset: got %b%b_%h want 00_00", tx_valid, halt, data_from_ram);
    end
    tx_ready = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    do_read(32'h100);
    checks++;
    if (data_from_ram !== 8'hA5) begin
      errors++; $display("FAIL ram_after_reset: got %h want a5", data_from_ram);
    end
  endtask

  initial begin
    test_reset();
    test_ram_single();
    test_burst();
    test_tx_fill();
    apply_reset();
    test_full_pushpop();
    test_rx();
    test_halt_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
